// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// mm:ss stopwatch controller. Two raw push buttons are synchronized and
// debounced. Each accepted press of btnU toggles between counting and
// paused. btnD clears the count, but only while paused. A prescaler divides
// clk down to one count increment every TICK_DIV cycles. The count is kept
// directly as four BCD digits.
//
// Parameters
//   TICK_DIV        clk cycles per count increment
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a button level
//
// Ports
//   clk        system clock, all logic on the rising edge
//   btnC       synchronous active-high reset
//   btnU       raw start/stop button (asynchronous)
//   btnD       raw clear button (asynchronous)
//   bcd[15:0]  {min tens, min units, sec tens, sec units}
//   running    high while counting
//   tick       one-cycle pulse in the cycle whose closing edge increments bcd
//   wrap       one-cycle pulse with the tick that rolls 59:59 over to 00:00
//   state_dbg  current controller state, for debug and assertion binding
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        btnU,
  input  logic        btnD,
  output logic [15:0] bcd,
  output logic        running,
  output logic        tick,
  output logic        wrap,
  output logic [1:0]  state_dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Bit 0 carries btnU, bit 1 carries btnD throughout the input path.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_q;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic          press_u;
  logic          press_d;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [15:0]   bcd_next;

  // ---------------------------------------------------------------------
  // Synchronizer and debouncer
  // ---------------------------------------------------------------------
  // A counter advances while the synchronized input differs from the held
  // level. Any cycle of agreement drops it back to 0, so only an unbroken run
  // of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_ff @(posedge clk) begin
    if (btnC) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= {btnD, btnU};
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          lvl[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level. It is masked during reset, so a press
  // that lands in a reset cycle is discarded instead of being acted on later.
  assign press   = lvl & ~lvl_q & {2{~btnC}};
  assign press_u = press[0];
  assign press_d = press[1];

  // ---------------------------------------------------------------------
  // BCD increment. The >= comparisons fold any out-of-range digit back to 0.
  // ---------------------------------------------------------------------
  always_comb begin
    bcd_next = bcd;
    if (bcd[3:0] >= 4'd9) begin
      bcd_next[3:0] = 4'd0;
      if (bcd[7:4] >= 4'd5) begin
        bcd_next[7:4] = 4'd0;
        if (bcd[11:8] >= 4'd9) begin
          bcd_next[11:8] = 4'd0;
          if (bcd[15:12] >= 4'd5) begin
            bcd_next[15:12] = 4'd0;
          end else begin
            bcd_next[15:12] = bcd[15:12] + 4'd1;
          end
        end else begin
          bcd_next[11:8] = bcd[11:8] + 4'd1;
        end
      end else begin
        bcd_next[7:4] = bcd[7:4] + 4'd1;
      end
    end else begin
      bcd_next[3:0] = bcd[3:0] + 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM, prescaler and count
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (btnC) begin
      state <= ST_IDLE;
      presc <= '0;
      bcd   <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          presc <= '0;
          if (press_u) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A tick and a stop press in the same cycle both take effect.
          if (presc == PRE_LAST) begin
            presc <= '0;
            bcd   <= bcd_next;
          end else begin
            presc <= presc + 1'b1;
          end
          if (press_u) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // A clear press wins over a resume press in the same cycle.
          if (press_d) begin
            state <= ST_IDLE;
            presc <= '0;
            bcd   <= 16'h0000;
          end else if (press_u) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_IDLE;
          presc <= '0;
          bcd   <= 16'h0000;
        end
      endcase
    end
  end

  assign running   = (state == ST_RUN);
  assign tick      = (state == ST_RUN) && (presc == PRE_LAST) && !btnC;
  assign wrap      = tick && (bcd == 16'h5959);
  assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
// A behavioural model keeps the count as an integer number of seconds and
// the button history as sample queues. It is compared against the DUT on
// every falling edge. Hand-computed literal checks in the stimulus pin
// latencies and key values.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        btnC;
  logic        btnU;
  logic        btnD;
  logic [15:0] bcd;
  logic        running;
  logic        tick;
  logic        wrap;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .btnC      (btnC),
    .btnU      (btnU),
    .btnD      (btnD),
    .bcd       (bcd),
    .running   (running),
    .tick      (tick),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} m_state_t;

  m_state_t    m_st    = M_IDLE;
  int          m_presc = 0;
  int          m_secs  = 0;
  bit [1:0]    m_sy_u  = '0;
  bit [1:0]    m_sy_d  = '0;
  bit          hist_u[$];
  bit          hist_d[$];
  bit          m_lvl_u = 1'b0;
  bit          m_lvl_d = 1'b0;
  bit          m_pu    = 1'b0;
  bit          m_pd    = 1'b0;
  bit          pu;
  bit          pd;
  bit          s_u;
  bit          s_d;
  int          old_secs;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int s);
    int mm = s / 60;
    int ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit all_differ(input bit q[$], input bit lvl);
    if (q.size() != DB) return 1'b0;
    foreach (q[i]) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    old_secs = m_secs;
    if (btnC) begin
      m_st    = M_IDLE;
      m_presc = 0;
      m_secs  = 0;
      m_sy_u  = '0;
      m_sy_d  = '0;
      hist_u.delete();
      hist_d.delete();
      m_lvl_u = 1'b0;
      m_lvl_d = 1'b0;
      m_pu    = 1'b0;
      m_pd    = 1'b0;
    end else begin
      // Press pulses visible during the cycle that this edge closes.
      pu = m_pu;
      pd = m_pd;
      // Two-stage delay, then a level flip after DB consecutive differing samples.
      s_u    = m_sy_u[1];
      m_sy_u = {m_sy_u[0], btnU};
      s_d    = m_sy_d[1];
      m_sy_d = {m_sy_d[0], btnD};
      hist_u.push_back(s_u);
      if (hist_u.size() > DB) void'(hist_u.pop_front());
      hist_d.push_back(s_d);
      if (hist_d.size() > DB) void'(hist_d.pop_front());
      m_pu = 1'b0;
      m_pd = 1'b0;
      if (all_differ(hist_u, m_lvl_u)) begin
        m_lvl_u = ~m_lvl_u;
        m_pu    = m_lvl_u;
      end
      if (all_differ(hist_d, m_lvl_d)) begin
        m_lvl_d = ~m_lvl_d;
        m_pd    = m_lvl_d;
      end
      case (m_st)
        M_IDLE: if (pu) begin
          m_st    = M_RUN;
          m_presc = 0;
        end
        M_RUN: begin
          if (m_presc == TD - 1) begin
            m_presc = 0;
            m_secs  = (m_secs + 1) % 3600;
          end else begin
            m_presc++;
          end
          if (pu) m_st = M_PAUSE;
        end
        default: begin
          if (pd) begin
            m_st    = M_IDLE;
            m_presc = 0;
            m_secs  = 0;
          end else if (pu) begin
            m_st = M_RUN;
          end
        end
      endcase
    end
    if (chk_en && m_secs != old_secs) exp_q.push_back(to_bcd(m_secs));
  end

  // ---------------- scoreboard / compare process ----------------
  logic [15:0] last_bcd;
  logic [1:0]  last_dbg;
  m_state_t    last_st;
  bit          e_tick;

  always @(negedge clk) begin
    if (chk_en) begin
      e_tick = (m_st == M_RUN) && (m_presc == TD - 1) && !btnC;
      check("bcd",     bcd,             to_bcd(m_secs));
      check("running", {15'd0, running}, {15'd0, m_st == M_RUN});
      check("tick",    {15'd0, tick},    {15'd0, e_tick});
      check("wrap",    {15'd0, wrap},    {15'd0, e_tick && (m_secs == 3599)});
      check("state_dbg_change", {15'd0, state_dbg != last_dbg}, {15'd0, m_st != last_st});
      last_dbg = state_dbg;
      last_st  = m_st;
      if (bcd !== last_bcd) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL bcd_change: got %h expected no change at %0t", bcd, $time);
        end else begin
          check("bcd_change", bcd, exp_q.pop_front());
        end
        last_bcd = bcd;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_bcd(input logic [15:0] v, input int limit);
    int k = 0;
    while (bcd !== v && k < limit) begin
      cyc(1);
      k++;
    end
    check("reach_bcd", bcd, v);
  endtask

  task automatic wait_tick(input int limit);
    int k = 0;
    while (tick !== 1'b1 && k < limit) begin
      cyc(1);
      k++;
    end
    check("reach_tick", {15'd0, tick}, 16'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    btnC = 1'b1;
    btnU = 1'b0;
    btnD = 1'b0;
    cyc(3);
    last_bcd = 16'h0000;
    last_dbg = state_dbg;
    last_st  = m_st;
    chk_en   = 1'b1;
    check("rst_bcd",     bcd,             16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_tick",    {15'd0, tick},    16'd0);
    check("rst_wrap",    {15'd0, wrap},    16'd0);
    btnC = 1'b0;
    cyc(2);

    // Glitch of 3 cycles: too short to be accepted.
    btnU = 1'b1;
    cyc(3);
    btnU = 1'b0;
    cyc(10);
    check("glitch_running", {15'd0, running}, 16'd0);

    // Start: running rises on the 7th edge after the button rises.
    btnU = 1'b1;
    cyc(6);
    check("start_lat_6", {15'd0, running}, 16'd0);
    cyc(1);
    check("start_lat_7", {15'd0, running}, 16'd1);
    btnU = 1'b0;
    cyc(9);
    check("first_tick",     {15'd0, tick}, 16'd1);
    check("first_tick_bcd", bcd,           16'h0000);
    btnU = 1'b1;  // lands the pause at prescaler 6
    cyc(1);
    check("first_inc", bcd, 16'h0001);
    cyc(6);
    check("paused",     {15'd0, running}, 16'd0);
    check("paused_bcd", bcd,              16'h0001);
    btnU = 1'b0;
    cyc(10);
    check("pause_hold", bcd, 16'h0001);
    btnU = 1'b1;
    cyc(6);
    check("resume_lat_6", {15'd0, running}, 16'd0);
    cyc(1);
    check("resume_lat_7", {15'd0, running}, 16'd1);
    btnU = 1'b0;
    cyc(2);
    check("resume_run3_tick", {15'd0, tick}, 16'd0);
    cyc(1);
    check("resume_run4_tick", {15'd0, tick}, 16'd1);
    cyc(1);
    check("resume_inc", bcd, 16'h0002);

    // Clear pressed while running: ignored.
    btnD = 1'b1;
    cyc(8);
    check("clr_in_run", {15'd0, running}, 16'd1);
    btnD = 1'b0;
    cyc(8);

    // Pause, then start and clear together: clear wins.
    btnU = 1'b1;
    cyc(8);
    btnU = 1'b0;
    cyc(8);
    check("pause2", {15'd0, running}, 16'd0);
    btnU = 1'b1;
    btnD = 1'b1;
    cyc(7);
    check("both_running", {15'd0, running}, 16'd0);
    check("both_bcd",     bcd,              16'h0000);
    btnU = 1'b0;
    btnD = 1'b0;
    cyc(8);

    // Clear pressed in idle: ignored.
    btnD = 1'b1;
    cyc(8);
    check("clr_in_idle", {15'd0, running}, 16'd0);
    btnD = 1'b0;
    cyc(8);

    // Reset while running at 01:23.
    btnU = 1'b1;
    cyc(7);
    check("start2", {15'd0, running}, 16'd1);
    btnU = 1'b0;
    wait_bcd(16'h0123, 1500);
    btnC = 1'b1;
    cyc(1);
    check("rst_run_bcd",     bcd,              16'h0000);
    check("rst_run_running", {15'd0, running}, 16'd0);
    cyc(1);
    btnC = 1'b0;
    cyc(40);
    check("post_rst_bcd", bcd, 16'h0000);

    // Reset in the middle of a debounce: the press restarts from scratch.
    btnU = 1'b1;
    cyc(4);
    btnC = 1'b1;
    cyc(1);
    btnC = 1'b0;
    cyc(6);
    check("mid_db_not_yet", {15'd0, running}, 16'd0);
    cyc(1);
    check("mid_db_start", {15'd0, running}, 16'd1);
    btnU = 1'b0;

    // Roll over from 59:58.
    wait_bcd(16'h5958, 40000);
    wait_tick(20);
    check("pre_wrap",  {15'd0, wrap}, 16'd0);
    cyc(1);
    check("bcd_5959", bcd, 16'h5959);
    wait_tick(20);
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    cyc(1);
    check("bcd_wrapped", bcd,           16'h0000);
    check("wrap_gone",   {15'd0, wrap}, 16'd0);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Backstop in case the stimulus never gets to its summary.
  initial begin
    #900000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, giving clk cycles per count increment (1 s at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable cycles required to accept a button level (10 ms).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port btnC, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port btnU, input, 1, the raw asynchronous start/stop button.
REQ-006 SHALL have port btnD, input, 1, the raw asynchronous clear button.
REQ-007 SHALL have port bcd, output, 16, the mm:ss count: [3:0] seconds units, [7:4] seconds tens, [11:8] minutes units, [15:12] minutes tens; it drives the 4-digit display stage's value input.
REQ-008 SHALL have port running, output, 1, high while in state RUN.
REQ-009 SHALL have port tick, output, 1, a one-cycle pulse on each count increment (debug header).
REQ-010 SHALL have port wrap, output, 1, a one-cycle pulse when the count rolls over from 59:59 to 00:00.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-012 SHALL hold a debounced level per button and change it only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts that button's count at 0.
REQ-013 SHALL generate a one-cycle press pulse in the cycle a debounced level goes 0->1; releases generate no pulse.
REQ-014 SHALL implement states IDLE, RUN and PAUSE.
REQ-015 In IDLE, a btnU press SHALL move to RUN with the prescaler at 0; a btnD press SHALL be ignored.
REQ-016 In RUN, a btnU press SHALL move to PAUSE; a btnD press SHALL be ignored.
REQ-017 In PAUSE, a btnU press SHALL move to RUN; a btnD press SHALL move to IDLE, clearing bcd and the prescaler.
REQ-018 If btnU and btnD press pulses coincide in PAUSE, btnD SHALL win: the block moves to IDLE and clears.
REQ-019 The prescaler SHALL count only in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-020 In RUN, when the prescaler equals TICK_DIV-1, it SHALL return to 0, tick SHALL be asserted that cycle, and bcd SHALL update on the same edge.
REQ-021 Digit rules: seconds units wrap 9->0 and carry; seconds tens wrap 5->0 and carry; minutes units wrap 9->0 and carry; minutes tens wrap 5->0 and assert wrap.
REQ-022 No digit SHALL ever hold a value outside its range (0-9 units, 0-5 tens).
REQ-023 If a tick and a btnU press coincide in RUN, the increment SHALL be applied and the state SHALL become PAUSE.
REQ-024 bcd SHALL change only on a tick, a clear or a reset.
REQ-025 The path from a press to a state change SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle.

Reset
REQ-026 With btnC high at a clk edge, the block SHALL enter IDLE and set bcd=16'h0000, running=0, tick=0, wrap=0, the prescaler to 0, the debounce counters to 0 and the debounced levels to 0.
REQ-027 Reset SHALL take precedence over every other event, including a reset in the middle of a debounce or in RUN.
REQ-028 The synchronizer flops SHALL also clear on reset.
REQ-029 While btnC is high, the block SHALL generate no press pulses.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4)
REQ-030 Reset then btnU press -> running=1, 2+4+1 cycles after btnU rises; first tick 10 cycles later; bcd=16'h0001.
REQ-031 btnU glitch high for 3 cycles, then low -> no press pulse and running stays 0.
REQ-032 Run from bcd=16'h5958 for two ticks -> bcd=16'h5959, then 16'h0000 with wrap pulsed for 1 cycle with the second tick.
REQ-033 Pause at prescaler=6, then resume -> next tick arrives after 4 RUN cycles and bcd holds its value while paused.
REQ-034 In PAUSE, btnU and btnD asserted together -> state IDLE, bcd=16'h0000, running=0; btnD pressed in RUN -> no effect.
REQ-035 btnC asserted in RUN at bcd=16'h0123 -> next cycle bcd=16'h0000, running=0, and no tick until a new btnU press.
